// File: rtl/wb_dest_demux_if.sv
// Bundle of the writeback demux handshake, result inputs and destination write ports.
// The producer side uses modport master; the demux itself uses modport slave.
interface wb_dest_demux_if;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    dest_mux_select;
    logic [9:0]    dest_addr;
    logic [5:0]    in_wfid;
    logic [2047:0] result_data;
    logic [63:0]   result_mask;
    logic [63:0]   exec_mask;
    logic          vgpr_wr_en;
    logic [9:0]    vgpr_wr_addr;
    logic [2047:0] vgpr_wr_data;
    logic [63:0]   vgpr_wr_mask;
    logic          sgpr_wr_en;
    logic [8:0]    sgpr_wr_addr;
    logic [31:0]   sgpr_wr_data;
    logic          exec_wr_vcc_lo_en;
    logic          exec_wr_vcc_hi_en;
    logic [63:0]   exec_wr_vcc_value;
    logic          exec_wr_exec_lo_en;
    logic          exec_wr_exec_hi_en;
    logic [63:0]   exec_wr_exec_value;
    logic          exec_wr_m0_en;
    logic [31:0]   exec_wr_m0_value;
    logic          exec_wr_scc_en;
    logic          exec_wr_scc_value;
    logic [5:0]    exec_wr_wfid;
    logic          done;
    logic          illegal;

    modport slave (
        input  in_valid, dest_mux_select, dest_addr, in_wfid, result_data, result_mask, exec_mask,
        output in_ready, vgpr_wr_en, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
        output sgpr_wr_en, sgpr_wr_addr, sgpr_wr_data,
        output exec_wr_vcc_lo_en, exec_wr_vcc_hi_en, exec_wr_vcc_value,
        output exec_wr_exec_lo_en, exec_wr_exec_hi_en, exec_wr_exec_value,
        output exec_wr_m0_en, exec_wr_m0_value, exec_wr_scc_en, exec_wr_scc_value,
        output exec_wr_wfid, done, illegal
    );

    modport master (
        output in_valid, dest_mux_select, dest_addr, in_wfid, result_data, result_mask, exec_mask,
        input  in_ready, vgpr_wr_en, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
        input  sgpr_wr_en, sgpr_wr_addr, sgpr_wr_data,
        input  exec_wr_vcc_lo_en, exec_wr_vcc_hi_en, exec_wr_vcc_value,
        input  exec_wr_exec_lo_en, exec_wr_exec_hi_en, exec_wr_exec_value,
        input  exec_wr_m0_en, exec_wr_m0_value, exec_wr_scc_en, exec_wr_scc_value,
        input  exec_wr_wfid, done, illegal
    );
endinterface

// File: rtl/wb_dest_demux.sv
// Writeback destination demux: one result per handshake to VGPR, SGPR or exec special registers.
// Define WB_DEST_DEMUX_SGPR_PAIR_EN to support two-beat SGPR-pair writes (select code 1100).
module wb_dest_demux (
    input  logic           clk,
    input  logic           rst,
    wb_dest_demux_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, PAIR_LO = 2'd2, PAIR_HI = 2'd3} state_t;
    state_t state_q, state_d;

    logic        xfer_s, pair_code_s, in_ready_s;
    logic [63:0] masked_s;
    logic [3:0]  sel_s;

    logic [8:0]  hold_addr_q;
    logic [31:0] hold_hi_q;
    logic [5:0]  hold_wfid_q;

    logic          vgpr_en_q, vgpr_en_d, sgpr_en_q, sgpr_en_d;
    logic [9:0]    vgpr_addr_q, vgpr_addr_d;
    logic [2047:0] vgpr_data_q, vgpr_data_d;
    logic [63:0]   vgpr_mask_q, vgpr_mask_d;
    logic [8:0]    sgpr_addr_q, sgpr_addr_d;
    logic [31:0]   sgpr_data_q, sgpr_data_d, m0_val_q, m0_val_d;
    logic          vcc_lo_q, vcc_lo_d, vcc_hi_q, vcc_hi_d, exec_lo_q, exec_lo_d, exec_hi_q, exec_hi_d;
    logic [63:0]   vcc_val_q, vcc_val_d, exec_val_q, exec_val_d;
    logic          m0_en_q, m0_en_d, scc_en_q, scc_en_d, scc_val_q, scc_val_d;
    logic [5:0]    wfid_q, wfid_d;
    logic          done_q, done_d, illegal_q, illegal_d;

    assign sel_s      = bus.dest_mux_select;
    assign in_ready_s = (state_q != PAIR_LO);
    assign xfer_s     = bus.in_valid & in_ready_s;
    assign masked_s   = bus.result_mask & bus.exec_mask;
`ifdef WB_DEST_DEMUX_SGPR_PAIR_EN
    assign pair_code_s = (sel_s == 4'b1100);
`else
    assign pair_code_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: a pair always spends one cycle in PAIR_LO, then PAIR_HI
    always_comb begin
        state_d = state_q;
        case (state_q)
            PAIR_LO: state_d = PAIR_HI;
            IDLE, WR, PAIR_HI: begin
                if (xfer_s) state_d = pair_code_s ? PAIR_LO : WR;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next write-port values: hi pair beat from the holding register, else decode the new transfer
    always_comb begin
        vgpr_en_d = 1'b0;  sgpr_en_d = 1'b0;  vcc_lo_d = 1'b0;  vcc_hi_d = 1'b0;
        exec_lo_d = 1'b0;  exec_hi_d = 1'b0;  m0_en_d = 1'b0;   scc_en_d = 1'b0;
        done_d = 1'b0;     illegal_d = 1'b0;
        vgpr_addr_d = vgpr_addr_q;  vgpr_data_d = vgpr_data_q;  vgpr_mask_d = vgpr_mask_q;
        sgpr_addr_d = sgpr_addr_q;  sgpr_data_d = sgpr_data_q;
        vcc_val_d = vcc_val_q;  exec_val_d = exec_val_q;  m0_val_d = m0_val_q;
        scc_val_d = scc_val_q;  wfid_d = wfid_q;
        if (state_q == PAIR_LO) begin
            sgpr_en_d   = 1'b1;
            sgpr_addr_d = hold_addr_q + 9'd1;
            sgpr_data_d = hold_hi_q;
            wfid_d      = hold_wfid_q;
            done_d      = 1'b1;
        end else if (xfer_s) begin
            wfid_d = bus.in_wfid;
            done_d = 1'b1;
            case (sel_s)
                4'b0010: begin
                    vgpr_en_d   = |bus.exec_mask;
                    vgpr_addr_d = bus.dest_addr;
                    vgpr_data_d = bus.result_data;
                    vgpr_mask_d = bus.exec_mask;
                end
                4'b0011: begin
                    sgpr_en_d   = 1'b1;
                    sgpr_addr_d = bus.dest_addr[8:0];
                    sgpr_data_d = bus.result_data[31:0];
                end
                4'b0100: begin vcc_lo_d = 1'b1;  vcc_val_d[31:0]   = bus.result_data[31:0]; end
                4'b0101: begin vcc_hi_d = 1'b1;  vcc_val_d[63:32]  = bus.result_data[31:0]; end
                4'b0110: begin m0_en_d = 1'b1;   m0_val_d          = bus.result_data[31:0]; end
                4'b0111: begin exec_lo_d = 1'b1; exec_val_d[31:0]  = bus.result_data[31:0]; end
                4'b1000: begin exec_hi_d = 1'b1; exec_val_d[63:32] = bus.result_data[31:0]; end
                4'b1011: begin scc_en_d = 1'b1;  scc_val_d         = bus.result_data[0];    end
                4'b1101: begin
                    vcc_lo_d  = 1'b1;
                    vcc_hi_d  = 1'b1;
                    vcc_val_d = masked_s;
                end
                4'b1100: begin
`ifdef WB_DEST_DEMUX_SGPR_PAIR_EN
                    sgpr_en_d   = 1'b1;
                    sgpr_addr_d = bus.dest_addr[8:0];
                    sgpr_data_d = masked_s[31:0];
                    done_d      = 1'b0;
`else
                    illegal_d = 1'b1;
`endif
                end
                default: illegal_d = 1'b1;
            endcase
        end else begin
            done_d = 1'b0;
        end
    end

    // Registered write ports and pair holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vgpr_en_q <= 1'b0;  vgpr_addr_q <= 10'd0;  vgpr_data_q <= 2048'd0;  vgpr_mask_q <= 64'd0;
            sgpr_en_q <= 1'b0;  sgpr_addr_q <= 9'd0;   sgpr_data_q <= 32'd0;
            vcc_lo_q <= 1'b0;   vcc_hi_q <= 1'b0;      vcc_val_q <= 64'd0;
            exec_lo_q <= 1'b0;  exec_hi_q <= 1'b0;     exec_val_q <= 64'd0;
            m0_en_q <= 1'b0;    m0_val_q <= 32'd0;     scc_en_q <= 1'b0;  scc_val_q <= 1'b0;
            wfid_q <= 6'd0;     done_q <= 1'b0;        illegal_q <= 1'b0;
            hold_addr_q <= 9'd0; hold_hi_q <= 32'd0;   hold_wfid_q <= 6'd0;
        end else begin
            vgpr_en_q <= vgpr_en_d;  vgpr_addr_q <= vgpr_addr_d;  vgpr_data_q <= vgpr_data_d;
            vgpr_mask_q <= vgpr_mask_d;
            sgpr_en_q <= sgpr_en_d;  sgpr_addr_q <= sgpr_addr_d;  sgpr_data_q <= sgpr_data_d;
            vcc_lo_q <= vcc_lo_d;    vcc_hi_q <= vcc_hi_d;        vcc_val_q <= vcc_val_d;
            exec_lo_q <= exec_lo_d;  exec_hi_q <= exec_hi_d;      exec_val_q <= exec_val_d;
            m0_en_q <= m0_en_d;      m0_val_q <= m0_val_d;
            scc_en_q <= scc_en_d;    scc_val_q <= scc_val_d;
            wfid_q <= wfid_d;        done_q <= done_d;            illegal_q <= illegal_d;
            if (xfer_s) begin
                hold_addr_q <= bus.dest_addr[8:0];
                hold_hi_q   <= masked_s[63:32];
                hold_wfid_q <= bus.in_wfid;
            end
        end
    end

    assign bus.in_ready           = in_ready_s;
    assign bus.vgpr_wr_en         = vgpr_en_q;
    assign bus.vgpr_wr_addr       = vgpr_addr_q;
    assign bus.vgpr_wr_data       = vgpr_data_q;
    assign bus.vgpr_wr_mask       = vgpr_mask_q;
    assign bus.sgpr_wr_en         = sgpr_en_q;
    assign bus.sgpr_wr_addr       = sgpr_addr_q;
    assign bus.sgpr_wr_data       = sgpr_data_q;
    assign bus.exec_wr_vcc_lo_en  = vcc_lo_q;
    assign bus.exec_wr_vcc_hi_en  = vcc_hi_q;
    assign bus.exec_wr_vcc_value  = vcc_val_q;
    assign bus.exec_wr_exec_lo_en = exec_lo_q;
    assign bus.exec_wr_exec_hi_en = exec_hi_q;
    assign bus.exec_wr_exec_value = exec_val_q;
    assign bus.exec_wr_m0_en      = m0_en_q;
    assign bus.exec_wr_m0_value   = m0_val_q;
    assign bus.exec_wr_scc_en     = scc_en_q;
    assign bus.exec_wr_scc_value  = scc_val_q;
    assign bus.exec_wr_wfid       = wfid_q;
    assign bus.done               = done_q;
    assign bus.illegal            = illegal_q;
endmodule

// File: tb/tb_wb_dest_demux.sv
// Randomized bench for wb_dest_demux: accepted results become a queue of expected write beats,
// and every cycle the write ports are compared against the beat at the head of that queue.
module tb_wb_dest_demux;
`ifdef WB_DEST_DEMUX_SGPR_PAIR_EN
    localparam bit PAIR_EN = 1'b1;
`else
    localparam bit PAIR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_dest_demux_if bus();
    wb_dest_demux dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]    code;
        logic [9:0]    addr;
        logic [5:0]    wfid;
        logic [2047:0] data;
        logic [63:0]   rmask;
        logic [63:0]   emask;
        bit            hi;
    } beat_t;
    beat_t model_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    logic          e_ready;
    logic          e_vgpr_en, e_sgpr_en, e_vcc_lo, e_vcc_hi, e_exec_lo, e_exec_hi;
    logic          e_m0_en, e_scc_en, e_scc_val, e_done, e_illegal;
    logic [9:0]    e_vgpr_addr;
    logic [2047:0] e_vgpr_data;
    logic [63:0]   e_vgpr_mask, e_vcc_val, e_exec_val;
    logic [8:0]    e_sgpr_addr;
    logic [31:0]   e_sgpr_data, e_m0_val;
    logic [5:0]    e_wfid;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2047:0] rand_data();
        logic [2047:0] d;
        for (int i = 0; i < 64; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        model_q.delete();
        e_ready = 1'b1;
        {e_vgpr_en, e_sgpr_en, e_vcc_lo, e_vcc_hi, e_exec_lo, e_exec_hi} = 6'd0;
        {e_m0_en, e_scc_en, e_scc_val, e_done, e_illegal} = 5'd0;
        e_vgpr_addr = 10'd0; e_vgpr_data = 2048'd0; e_vgpr_mask = 64'd0;
        e_vcc_val = 64'd0;   e_exec_val = 64'd0;    e_sgpr_addr = 9'd0;
        e_sgpr_data = 32'd0; e_m0_val = 32'd0;      e_wfid = 6'd0;
    endtask

    // Apply the next queued beat (if any) to the expected port state
    task automatic model_issue();
        beat_t b;
        logic [63:0] m;
        int nxt;
        {e_vgpr_en, e_sgpr_en, e_vcc_lo, e_vcc_hi, e_exec_lo, e_exec_hi} = 6'd0;
        {e_m0_en, e_scc_en, e_done, e_illegal} = 4'd0;
        if (model_q.size() != 0) begin
            b = model_q.pop_front();
            m = b.rmask & b.emask;
            e_wfid = b.wfid;
            e_done = 1'b1;
            if (b.hi) begin
                nxt = (int'(b.addr[8:0]) + 1) % 512;
                e_sgpr_en = 1'b1; e_sgpr_addr = 9'(nxt); e_sgpr_data = m[63:32];
            end else begin
                case (b.code)
                    4'd2: begin
                        e_vgpr_en = (b.emask != 64'd0);
                        e_vgpr_addr = b.addr; e_vgpr_data = b.data; e_vgpr_mask = b.emask;
                    end
                    4'd3:  begin e_sgpr_en = 1'b1; e_sgpr_addr = b.addr[8:0]; e_sgpr_data = b.data[31:0]; end
                    4'd4:  begin e_vcc_lo = 1'b1;  e_vcc_val[31:0]   = b.data[31:0]; end
                    4'd5:  begin e_vcc_hi = 1'b1;  e_vcc_val[63:32]  = b.data[31:0]; end
                    4'd6:  begin e_m0_en = 1'b1;   e_m0_val          = b.data[31:0]; end
                    4'd7:  begin e_exec_lo = 1'b1; e_exec_val[31:0]  = b.data[31:0]; end
                    4'd8:  begin e_exec_hi = 1'b1; e_exec_val[63:32] = b.data[31:0]; end
                    4'd11: begin e_scc_en = 1'b1;  e_scc_val         = b.data[0];    end
                    4'd13: begin e_vcc_lo = 1'b1;  e_vcc_hi = 1'b1;  e_vcc_val = m;  end
                    4'd12: begin
                        if (PAIR_EN) begin
                            e_sgpr_en = 1'b1; e_sgpr_addr = b.addr[8:0]; e_sgpr_data = m[31:0];
                            e_done = 1'b0;
                        end else begin
                            e_illegal = 1'b1;
                        end
                    end
                    default: e_illegal = 1'b1;
                endcase
            end
        end
        e_ready = (model_q.size() == 0);
    endtask

    task automatic compare_all();
        logic [10:0] so, se;
        so = {bus.vgpr_wr_en, bus.sgpr_wr_en, bus.exec_wr_vcc_lo_en, bus.exec_wr_vcc_hi_en,
              bus.exec_wr_exec_lo_en, bus.exec_wr_exec_hi_en, bus.exec_wr_m0_en, bus.exec_wr_scc_en,
              bus.done, bus.illegal, bus.in_ready};
        se = {e_vgpr_en, e_sgpr_en, e_vcc_lo, e_vcc_hi, e_exec_lo, e_exec_hi, e_m0_en, e_scc_en,
              e_done, e_illegal, e_ready};
        check_val("strobes", 64'(so), 64'(se));
        check_val("vgpr_addr", 64'(bus.vgpr_wr_addr), 64'(e_vgpr_addr));
        check_val("vgpr_mask", bus.vgpr_wr_mask, e_vgpr_mask);
        check_val("vgpr_data_eq", 64'(bus.vgpr_wr_data === e_vgpr_data), 64'd1);
        check_val("sgpr_addr", 64'(bus.sgpr_wr_addr), 64'(e_sgpr_addr));
        check_val("sgpr_data", 64'(bus.sgpr_wr_data), 64'(e_sgpr_data));
        check_val("vcc_value", bus.exec_wr_vcc_value, e_vcc_val);
        check_val("exec_value", bus.exec_wr_exec_value, e_exec_val);
        check_val("m0_value", 64'(bus.exec_wr_m0_value), 64'(e_m0_val));
        check_val("scc_value", 64'(bus.exec_wr_scc_value), 64'(e_scc_val));
        check_val("wfid", 64'(bus.exec_wr_wfid), 64'(e_wfid));
    endtask

    // One clock: record the transfer (if any) at the edge, then check the resulting beat
    task automatic step();
        beat_t b;
        @(posedge clk);
        if (bus.in_valid && e_ready) begin
            b.code = bus.dest_mux_select; b.addr = bus.dest_addr; b.wfid = bus.in_wfid;
            b.data = bus.result_data; b.rmask = bus.result_mask; b.emask = bus.exec_mask;
            b.hi = 1'b0;
            model_q.push_back(b);
            if (PAIR_EN && b.code == 4'b1100) begin
                b.hi = 1'b1;
                model_q.push_back(b);
            end
        end
        #1;
        model_issue();
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [9:0] a,
                         input logic [31:0] lane0, input logic [63:0] rm, input logic [63:0] em);
        logic [2047:0] d;
        d = rand_data();
        d[31:0] = lane0;
        bus.in_valid = v; bus.dest_mux_select = c; bus.dest_addr = a;
        bus.in_wfid = 6'($urandom); bus.result_data = d; bus.result_mask = rm; bus.exec_mask = em;
    endtask

    // Asynchronous reset between edges, held across one rising edge
    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] c;
        logic [63:0] em;
        drive(1'b0, 4'd0, 10'd0, 32'd0, 64'd0, 64'd0);
        model_reset();
        #2;
        do_reset();

        drive(1'b1, 4'b0010, 10'h3A5, $urandom, 64'd0, 64'hFFFF_0000_FFFF_0000);
        step();
        check_val("tp_vgpr_mask", bus.vgpr_wr_mask, 64'hFFFF_0000_FFFF_0000);
        drive(1'b1, 4'b0110, 10'h000, 32'hDEAD_BEEF, 64'd0, 64'd0);
        step();
        check_val("tp_m0_value", 64'(bus.exec_wr_m0_value), 64'h0000_0000_DEAD_BEEF);
        drive(1'b1, 4'b0101, 10'h000, 32'h1234_5678, 64'd0, 64'd0);
        step();
        check_val("tp_vcc_hi", 64'(bus.exec_wr_vcc_value[63:32]), 64'h0000_0000_1234_5678);
        drive(1'b1, 4'b1011, 10'h000, 32'h0000_0001, 64'd0, 64'd0);
        step();
        drive(1'b1, 4'b1100, 10'h1FF, $urandom, 64'hAAAA_5555_0F0F_F0F0, {64{1'b1}});
        step();
        drive(1'b1, 4'b0011, 10'h011, $urandom, 64'd0, 64'd0);
        step();
        step();
        drive(1'b1, 4'b0010, 10'h123, $urandom, 64'd0, 64'd0);
        step();
        drive(1'b1, 4'b1111, 10'h000, $urandom, 64'd0, 64'd0);
        step();
        drive(1'b1, 4'b1101, 10'h000, $urandom, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        step();
        drive(1'b0, 4'd0, 10'd0, 32'd0, 64'd0, 64'd0);
        step();

        drive(1'b1, 4'b1100, 10'h0A0, $urandom, 64'h1111_2222_3333_4444, {64{1'b1}});
        step();
        do_reset();
        step();
        step();

        for (int i = 0; i < 3000; i++) begin
            c  = ($urandom_range(0, 3) == 0) ? 4'b1100 : 4'($urandom_range(0, 15));
            em = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            drive($urandom_range(0, 3) != 0, c, 10'($urandom), $urandom,
                  {32'($urandom), 32'($urandom)}, em);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
